// File: rtl/score_keeper.sv
// score_keeper: two-player score tracking and serve sequencing for a paddle game
// Ports:
//   i_clk          system clock, all registers update on its rising edge
//   i_reset        asynchronous active-high reset
//   i_frame_tick   one-cycle pulse per video frame, paces the serve delay
//   i_mode         game mode, 000 means no game
//   i_valid        game-active qualifier from the game controller
//   i_miss_1       ball passed player 1's paddle, player 2 scores
//   i_miss_2       ball passed player 2's paddle, player 1 scores
//   o_score_1      player 1 score
//   o_score_2      player 2 score
//   o_ball_release ball motion enabled, high only during a rally
//   o_serve_dir    serve direction, 0 toward player 1, 1 toward player 2
//   o_point_strobe one-cycle pulse in the cycle after a score increments
module score_keeper #(
    parameter logic [8:0] MaxScore   = 9'd10,
    parameter int         ServeDelay = 60
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_tick,
    input  logic [2:0] i_mode,
    input  logic       i_valid,
    input  logic       i_miss_1,
    input  logic       i_miss_2,
    output logic [8:0] o_score_1,
    output logic [8:0] o_score_2,
    output logic       o_ball_release,
    output logic       o_serve_dir,
    output logic       o_point_strobe
);
    localparam int CW = (ServeDelay > 0) ? $clog2(ServeDelay + 1) : 1;
    localparam logic [CW-1:0] Reload = CW'(ServeDelay);

    typedef enum logic [1:0] {IDLE, SERVE, RALLY, DONE} state_t;

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [8:0]      r_score_1, w_score_1, r_score_2, w_score_2;
    logic            r_dir, w_dir, r_strobe, w_strobe;
    logic            w_active, w_p1, w_p2;

    assign w_active = i_valid && (i_mode != 3'b000);
    // A simultaneous double miss is a void point: neither side scores.
    assign w_p1 = i_miss_2 && !i_miss_1 && (r_score_1 < MaxScore);
    assign w_p2 = i_miss_1 && !i_miss_2 && (r_score_2 < MaxScore);

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_score_1 = r_score_1;
        w_score_2 = r_score_2;
        w_dir     = r_dir;
        w_strobe  = 1'b0;
        if (!w_active) begin
            w_state   = IDLE;
            w_cnt     = '0;
            w_score_1 = '0;
            w_score_2 = '0;
            w_dir     = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state = SERVE;
                    w_cnt   = Reload;
                end
                SERVE: begin
                    if (i_frame_tick) begin
                        if (r_cnt == '0) w_state = RALLY;
                        else w_cnt = r_cnt - 1'b1;
                    end
                end
                RALLY: begin
                    if (i_miss_1 || i_miss_2) begin
                        w_state = SERVE;
                        w_cnt   = Reload;
                        if (w_p1) begin
                            w_score_1 = r_score_1 + 9'd1;
                            w_dir     = 1'b1;
                            w_strobe  = 1'b1;
                            if (w_score_1 == MaxScore) w_state = DONE;
                        end else if (w_p2) begin
                            w_score_2 = r_score_2 + 9'd1;
                            w_dir     = 1'b0;
                            w_strobe  = 1'b1;
                            if (w_score_2 == MaxScore) w_state = DONE;
                        end
                    end
                end
                default: w_state = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_score_1 <= '0;
            r_score_2 <= '0;
            r_dir     <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_score_1 <= w_score_1;
            r_score_2 <= w_score_2;
            r_dir     <= w_dir;
            r_strobe  <= w_strobe;
        end
    end

    assign o_score_1      = r_score_1;
    assign o_score_2      = r_score_2;
    assign o_serve_dir    = r_dir;
    assign o_point_strobe = r_strobe;
    assign o_ball_release = (r_state == RALLY);
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed self-checking bench for score_keeper with ServeDelay=3
module tb_score_keeper;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       valid = 1'b0;
    logic       miss_1 = 1'b0;
    logic       miss_2 = 1'b0;
    logic [8:0] score_1, score_2;
    logic       ball, dir, strobe;
    int         n_tests = 0;
    int         n_fail = 0;

    score_keeper #(.MaxScore(9'd10), .ServeDelay(3)) dut (
        .i_clk(clk), .i_reset(rst), .i_frame_tick(frame_tick), .i_mode(mode),
        .i_valid(valid), .i_miss_1(miss_1), .i_miss_2(miss_2),
        .o_score_1(score_1), .o_score_2(score_2), .o_ball_release(ball),
        .o_serve_dir(dir), .o_point_strobe(strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int s1, input int s2, input int b, input int d, input int st);
        check({tag, ".s1"}, 32'(score_1), 32'(s1));
        check({tag, ".s2"}, 32'(score_2), 32'(s2));
        check({tag, ".ball"}, 32'(ball), 32'(b));
        check({tag, ".dir"}, 32'(dir), 32'(d));
        check({tag, ".strobe"}, 32'(strobe), 32'(st));
    endtask

    // Counts frame_ticks until the ball is released, with an idle cycle between ticks.
    task automatic serve_wait(input string tag);
        int n = 0;
        for (int i = 1; i <= 8 && n == 0; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
            if (ball) n = i;
        end
        check(tag, 32'(n), 32'd4);
    endtask

    task automatic miss(input logic a, input logic b);
        miss_1 = a;
        miss_2 = b;
        @(negedge clk);
        miss_1 = 1'b0;
        miss_2 = 1'b0;
    endtask

    initial begin
        #1;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all("idle_inactive", 0, 0, 0, 0, 0);
        valid = 1'b1;
        mode = 3'b001;
        @(negedge clk);
        check("serve_ball0", 32'(ball), 32'd0);
        serve_wait("serve_first");

        miss(1'b0, 1'b1);
        check_all("point_p1", 1, 0, 0, 1, 1);
        @(negedge clk);
        check("strobe_one_cycle", 32'(strobe), 32'd0);
        miss(1'b0, 1'b1);
        check_all("serve_miss_ignored", 1, 0, 0, 1, 0);
        serve_wait("serve_after_point");

        miss(1'b1, 1'b1);
        check_all("double_miss", 1, 0, 0, 1, 0);
        serve_wait("serve_after_double");

        miss(1'b1, 1'b0);
        check_all("point_p2", 1, 1, 0, 0, 1);
        mode = 3'b011;
        serve_wait("serve_mode_change");
        check("mode_change_s2", 32'(score_2), 32'd1);

        for (int i = 0; i < 8; i++) begin
            miss(1'b1, 1'b0);
            serve_wait("serve_loop_p2");
        end
        check("s2_nine", 32'(score_2), 32'd9);
        miss(1'b1, 1'b0);
        check_all("game_end_p2", 1, 10, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
        check("done_ball_held", 32'(ball), 32'd0);
        miss(1'b1, 1'b0);
        miss(1'b0, 1'b1);
        check_all("done_miss_ignored", 1, 10, 0, 0, 0);

        valid = 1'b0;
        @(negedge clk);
        check_all("abort_p2", 0, 0, 0, 0, 0);
        valid = 1'b1;
        @(negedge clk);
        serve_wait("serve_after_abort");

        for (int i = 0; i < 9; i++) begin
            miss(1'b0, 1'b1);
            serve_wait("serve_loop_p1");
        end
        miss(1'b0, 1'b1);
        check_all("game_end_p1", 10, 0, 0, 1, 1);
        miss(1'b0, 1'b1);
        check("s1_no_exceed", 32'(score_1), 32'd10);
        mode = 3'b000;
        @(negedge clk);
        mode = 3'b100;
        check_all("abort_p1", 0, 0, 0, 0, 0);
        @(negedge clk);
        serve_wait("serve_new_game");
        miss(1'b0, 1'b1);
        serve_wait("serve_pre_reset");

        @(posedge clk);
        #2 miss_2 = 1'b1;
        #1 rst = 1'b1;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        miss_2 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_all("post_reset", 0, 0, 0, 0, 0);
        serve_wait("serve_post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter MaxScore, default 9'd10, winning score; the game ends when either score reaches it.
REQ-002 Parameter ServeDelay, default 60, number of frame_tick pulses to wait before each serve.
REQ-003 Clk  input  1  system clock; every register updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 frame_tick  input  1  one-Clk-cycle pulse, once per video frame.
REQ-006 Mode  input  3  game mode: 000 none, 001 easy, 010 medium, 011 hard, 100 AI.
REQ-007 valid  input  1  game-active qualifier from the game controller; 0 means no game in progress.
REQ-008 miss_1  input  1  one-cycle pulse; the ball passed player 1's paddle, so player 2 scores.
REQ-009 miss_2  input  1  one-cycle pulse; the ball passed player 2's paddle, so player 1 scores.
REQ-010 score_1  output  9  player 1 score, registered.
REQ-011 score_2  output  9  player 2 score, registered.
REQ-012 ball_release  output  1  1 means ball motion is enabled.
REQ-013 serve_dir  output  1  serve direction: 0 toward player 1, 1 toward player 2.
REQ-014 point_strobe  output  1  one-cycle pulse, asserted the cycle after a score changes.

Function
REQ-015 The block SHALL implement an FSM with states IDLE, SERVE, RALLY and DONE.
REQ-016 Definition: "active" means valid==1 and Mode!=000.
- In any state, the cycle after active is 0, the FSM SHALL enter IDLE.
- Entering IDLE SHALL clear score_1, score_2 and serve_dir to 0.
- This rule has priority over every other transition.
REQ-017 In IDLE:
- Outputs: scores held at 0, ball_release=0.
- When active is 1, the FSM SHALL enter SERVE and load the delay counter with ServeDelay.
REQ-018 In SERVE:
- ball_release=0.
- The delay counter SHALL decrement by 1 on each frame_tick.
- When the counter is 0 and frame_tick is high, the FSM SHALL enter RALLY.
- The SERVE-to-RALLY latency is exactly ServeDelay+1 frame_ticks.
REQ-019 In RALLY:
- ball_release=1.
- miss_2 alone SHALL increment score_1 by 1 and set serve_dir=1.
- miss_1 alone SHALL increment score_2 by 1 and set serve_dir=0.
- Both effects are registered on the same edge as the state change.
REQ-020 In RALLY, if miss_1 and miss_2 are high in the same cycle:
- No score SHALL change and point_strobe SHALL stay 0.
- serve_dir is unchanged.
- The FSM SHALL re-enter SERVE with the counter reloaded.
REQ-021 After a scoring event in RALLY:
- If the incremented score equals MaxScore, the FSM SHALL enter DONE.
- Otherwise it SHALL enter SERVE with the counter reloaded to ServeDelay.
REQ-022 In DONE:
- ball_release=0.
- Scores SHALL be held unchanged until active falls (see REQ-016).
REQ-023 miss_1 and miss_2 SHALL be ignored in IDLE, SERVE and DONE.
REQ-024 Scores SHALL never exceed MaxScore; no wrap-around is permitted.
REQ-025 point_strobe SHALL be high for exactly one cycle following each score increment, and never in any other case.
REQ-026 A Mode change while valid stays high and Mode stays nonzero SHALL NOT disturb state or scores.
REQ-027 The delay counter SHALL be sized to hold ServeDelay.
- Counter value 0 is the terminal count.
- The counter SHALL NOT underflow.

Reset
REQ-028 Asserting Reset SHALL immediately place the block in this state, independent of Clk:
- state=IDLE, score_1=0, score_2=0, serve_dir=0, ball_release=0, point_strobe=0, delay counter=0.
REQ-029 Reset asserted mid-rally SHALL discard all pending miss pulses.
REQ-030 After Reset deasserts, the FSM SHALL start from IDLE on the next Clk edge.

Verification
REQ-031 Serve timing (ServeDelay=3): Reset, then valid=1, Mode=001 -> ball_release rises after exactly 4 frame_ticks.
REQ-032 Single point: in RALLY, one-cycle miss_2 pulse ->
- score_1=1, serve_dir=1, point_strobe high for 1 cycle;
- ball_release=0 until ServeDelay+1 further frame_ticks.
REQ-033 Game end: score_2=9, then miss_1 ->
- score_2=10, state DONE, ball_release stays 0;
- further miss pulses are ignored.
REQ-034 Simultaneous misses: miss_1=miss_2=1 in the same RALLY cycle -> scores unchanged, no point_strobe, re-serve.
REQ-035 Abort: from DONE with score_1=10, drop valid for one cycle -> scores=0 and state IDLE; raise valid -> a new serve starts.
REQ-036 Asynchronous reset: assert Reset between Clk edges during RALLY -> all outputs are 0 before the next Clk edge.
